// File: rtl/otter_fetch_unit_if.sv
// Bundles the fetch unit's control, target, instruction-memory and
// decode-side signals. The "master" modport is the fetch unit itself;
// "slave" is everything around it (control FSM, address generators,
// CSR file, instruction memory and decoder).
//
// Instruction-memory handshake: IMEM_REQ is high while a fetch is
// outstanding and IMEM_ADDR is held stable until the cycle in which
// IMEM_ACK is high. IMEM_RDATA is only meaningful on a cycle where both
// IMEM_REQ and IMEM_ACK are high, and the word is taken on that rising
// edge. IMEM_ACK seen without IMEM_REQ carries no transfer.
interface otter_fetch_unit_if;
    logic        PC_WRITE;
    logic [2:0]  PC_SOURCE;
    logic [31:0] JALR_TGT;
    logic [31:0] BRANCH_TGT;
    logic [31:0] JAL_TGT;
    logic [31:0] MTVEC;
    logic [31:0] MEPC;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_ACK;
    logic [31:0] IMEM_RDATA;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic [31:0] IR;
    logic        IR_VALID;
    logic        FETCH_ERR;

    modport master (
        input  PC_WRITE, PC_SOURCE, JALR_TGT, BRANCH_TGT, JAL_TGT, MTVEC, MEPC,
        input  IMEM_ACK, IMEM_RDATA,
        output IMEM_REQ, IMEM_ADDR, PC, PC_PLUS4, IR, IR_VALID, FETCH_ERR
    );

    modport slave (
        output PC_WRITE, PC_SOURCE, JALR_TGT, BRANCH_TGT, JAL_TGT, MTVEC, MEPC,
        output IMEM_ACK, IMEM_RDATA,
        input  IMEM_REQ, IMEM_ADDR, PC, PC_PLUS4, IR, IR_VALID, FETCH_ERR
    );
endinterface

// File: rtl/otter_fetch_unit.sv
// OTTER RV32I instruction-fetch stage. Owns the PC, picks the next PC
// from the jump/branch/trap candidates, fetches over the IMEM req/ack
// handshake and holds the instruction in IR for immediate generation
// and decode. dbg_state exposes the FSM (0 = FETCH, 1 = HOLD).
module otter_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic               CLK,
    input  logic               RST,
    otter_fetch_unit_if.master bus,
    output logic               dbg_state
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] ir;
    logic        ir_valid;
    logic        fetch_err;
    logic [31:0] target;

    assign pc_plus4 = pc + 32'd4;

    // Next-PC candidate select; unused encodings fall back to sequential.
    always_comb begin
        target = pc_plus4;
        case (bus.PC_SOURCE)
            3'd1:    target = bus.JALR_TGT;
            3'd2:    target = bus.BRANCH_TGT;
            3'd3:    target = bus.JAL_TGT;
            3'd4:    target = bus.MTVEC;
            3'd5:    target = bus.MEPC;
            default: target = pc_plus4;
        endcase
    end

    // Fetch/hold FSM with PC, IR and status registers. A misaligned target
    // leaves everything in place and raises a one-cycle FETCH_ERR so the
    // trap logic can redirect to MTVEC.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc        <= RESET_VECTOR;
            ir        <= NOP;
            ir_valid  <= 1'b0;
            fetch_err <= 1'b0;
            state     <= S_FETCH;
        end else begin
            fetch_err <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (bus.IMEM_ACK) begin
                        ir       <= bus.IMEM_RDATA;
                        ir_valid <= 1'b1;
                        state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.PC_WRITE) begin
                        if (target[1:0] == 2'b00) begin
                            pc       <= target;
                            ir_valid <= 1'b0;
                            state    <= S_FETCH;
                        end else begin
                            fetch_err <= 1'b1;
                        end
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    // The request is a state decode, masked while reset is asserted so an
    // aborted fetch never reaches memory.
    assign bus.IMEM_REQ  = (state == S_FETCH) && !RST;
    assign bus.IMEM_ADDR = pc;
    assign bus.PC        = pc;
    assign bus.PC_PLUS4  = pc_plus4;
    assign bus.IR        = ir;
    assign bus.IR_VALID  = ir_valid;
    assign bus.FETCH_ERR = fetch_err;
    assign dbg_state     = (state == S_HOLD);

endmodule
